// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 32x32 register-file read mux among NUM_REQ requesters.
// One read accepted per cycle; response returns exactly two cycles after acceptance.
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [5*NUM_REQ-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [4:0]           mux_select_o,
    input  logic [31:0]          mux_data_i,
    output logic                 rsp_valid_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [31:0]          rsp_data_o
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SUM_W  = ID_W + 1;

    logic [ADDR_W-1:0] addr_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_a[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    end

    logic [ID_W-1:0]   rr_ptr_q,     rr_ptr_d;
    logic [ADDR_W-1:0] mux_select_q, mux_select_d;
    logic              s1_valid_q,   s1_valid_d;
    logic [ID_W-1:0]   s1_id_q,      s1_id_d;
    logic              s1_zero_q,    s1_zero_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;

    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    gnt_id_c;
    logic               accept_c;
    logic [SUM_W-1:0]   scan_c;
    logic [ID_W-1:0]    idx_c;

    // Scan from rr_ptr upward (mod NUM_REQ); first valid requester wins.
    always_comb begin
        grant_c  = '0;
        gnt_id_c = '0;
        accept_c = 1'b0;
        scan_c   = '0;
        idx_c    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_c = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (scan_c >= SUM_W'(NUM_REQ)) begin
                scan_c = scan_c - SUM_W'(NUM_REQ);
            end
            idx_c = ID_W'(scan_c);
            if (!accept_c && req_valid_i[idx_c]) begin
                accept_c = 1'b1;
                gnt_id_c = idx_c;
            end
        end
        grant_c[gnt_id_c] = accept_c;
    end

    assign req_ready_o = grant_c;

    // Stage 1 drives the mux select; stage 2 captures mux data for the owning requester.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        mux_select_d = mux_select_q;
        s1_valid_d   = accept_c;
        s1_id_d      = s1_id_q;
        s1_zero_d    = s1_zero_q;
        rsp_valid_d  = s1_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        if (accept_c) begin
            rr_ptr_d     = (gnt_id_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
            mux_select_d = addr_a[gnt_id_c];
            s1_id_d      = gnt_id_c;
            s1_zero_d    = ZERO_R0 && (addr_a[gnt_id_c] == '0);
        end
        if (s1_valid_q) begin
            rsp_id_d   = s1_id_q;
            rsp_data_d = s1_zero_q ? '0 : mux_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            mux_select_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s1_zero_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            mux_select_q <= mux_select_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_zero_q    <= s1_zero_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign mux_select_o = mux_select_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter; a second instance with ZERO_R0=0 covers pass-through of address 0.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_addr = '0;
    logic        mux_ones = 1'b0;

    logic [3:0]  req_ready,  req_ready_nz;
    logic [4:0]  mux_select, mux_select_nz;
    logic [31:0] mux_data,   mux_data_nz;
    logic        rsp_valid,  rsp_valid_nz;
    logic [1:0]  rsp_id,     rsp_id_nz;
    logic [31:0] rsp_data,   rsp_data_nz;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Register-file model: reg r holds 32'hDEAD_00rr, or all ones when mux_ones is set.
    assign mux_data    = mux_ones ? 32'hFFFF_FFFF : {16'hDEAD, 11'h0, mux_select};
    assign mux_data_nz = mux_ones ? 32'hFFFF_FFFF : {16'hDEAD, 11'h0, mux_select_nz};

    regfile_read_arbiter #(.NUM_REQ(4), .ID_W(2), .ZERO_R0(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_ready_o  (req_ready),
        .mux_select_o (mux_select),
        .mux_data_i   (mux_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data)
    );

    regfile_read_arbiter #(.NUM_REQ(4), .ID_W(2), .ZERO_R0(1'b0)) dut_nz (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_ready_o  (req_ready_nz),
        .mux_select_o (mux_select_nz),
        .mux_data_i   (mux_data_nz),
        .rsp_valid_o  (rsp_valid_nz),
        .rsp_id_o     (rsp_id_nz),
        .rsp_data_o   (rsp_data_nz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[5*i +: 5] = a;
    endtask

    task automatic do_reset();
        req_valid = '0;
        mux_ones  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] exp_rdy2 [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    logic [1:0] exp_id2  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_rdy3 [6] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
    logic [1:0] exp_id3  [4] = '{2'd0, 2'd2, 2'd0, 2'd2};

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_mux_select", 32'(mux_select), 32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_rsp_data",   rsp_data,        32'd0);
        chk("rst_ready_idle", 32'(req_ready),  32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_ready_prio", 32'(req_ready),  32'b0001);
        req_valid = '0;
        tick();
        rst = 1'b0;

        // Single read from requester 1, addr 7
        set_addr(1, 5'd7);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_select",    32'(mux_select), 32'd7);
        chk("t1_valid_T1",  32'(rsp_valid),  32'd0);
        tick();
        @(negedge clk);
        chk("t1_valid_T2",  32'(rsp_valid),  32'd1);
        chk("t1_id",        32'(rsp_id),     32'd1);
        chk("t1_data",      rsp_data,        32'hDEAD_0007);
        tick();
        @(negedge clk);
        chk("t1_pulse_end", 32'(rsp_valid),  32'd0);
        chk("t1_id_hold",   32'(rsp_id),     32'd1);
        chk("t1_data_hold", rsp_data,        32'hDEAD_0007);

        // All four requesters valid, addrs 3..6
        do_reset();
        set_addr(0, 5'd3); set_addr(1, 5'd4); set_addr(2, 5'd5); set_addr(3, 5'd6);
        req_valid = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t2_ready", 32'(req_ready), 32'(exp_rdy2[k]));
            chk("t2_valid", 32'(rsp_valid), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                chk("t2_id",   32'(rsp_id), 32'(exp_id2[k-2]));
                chk("t2_data", rsp_data,    32'hDEAD_0003 + 32'(exp_id2[k-2]));
            end
            tick();
        end
        req_valid = '0;

        // Requesters 0 and 2 continuously valid -> alternate
        do_reset();
        req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3_ready", 32'(req_ready), 32'(exp_rdy3[k]));
            if (k >= 2) begin
                chk("t3_id",   32'(rsp_id), 32'(exp_id3[k-2]));
                chk("t3_data", rsp_data,    (exp_id3[k-2] == 2'd0) ? 32'hDEAD_0003 : 32'hDEAD_0005);
            end
            tick();
        end
        req_valid = '0;

        // Address 0 with mux driving all ones
        do_reset();
        mux_ones = 1'b1;
        set_addr(0, 5'd0);
        req_valid = 4'b0001;
        tick();
        set_addr(0, 5'd9);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t4_valid",   32'(rsp_valid),    32'd1);
        chk("t4_zero",    rsp_data,          32'h0);
        chk("t4_nz_pass", rsp_data_nz,       32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        chk("t4_nonzero_addr", rsp_data,     32'hFFFF_FFFF);
        tick();
        mux_ones = 1'b0;

        // Grant to 3, idle, then 1010 -> requester 1 first
        do_reset();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t5_ready3", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_idle", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 4'b1010;
        @(negedge clk);
        chk("t5_ready1", 32'(req_ready), 32'b0010);
        tick();
        @(negedge clk);
        chk("t5_ready3b", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;

        // Reset the cycle after an accept
        do_reset();
        set_addr(0, 5'd7);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("t6_select_clr", 32'(mux_select), 32'd0);
        chk("t6_valid_clr",  32'(rsp_valid),  32'd0);
        chk("t6_data_clr",   rsp_data,        32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        set_addr(2, 5'd5);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t6_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t6_valid_T1", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_valid_T2", 32'(rsp_valid), 32'd1);
        chk("t6_id",       32'(rsp_id),    32'd2);
        chk("t6_data",     rsp_data,       32'hDEAD_0005);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
